// File: rtl/reg_sel_pkg.sv
// Shared encodings for the register-select decoder: request modes and FSM states.
package reg_sel_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SCAN
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decoder with an in-range flag for partial output sets.
module onehot_dec #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned N_OUT = 8
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot,
  output logic             in_range
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      onehot[i] = (sel == SEL_W'(i));
    end
  end

  assign in_range = (32'(sel) < N_OUT);

endmodule

// File: rtl/reg_sel_decoder.sv
// Registered register-select decoder: one-hot write strobe with hold, timed-pulse and scan modes,
// request/ready handshake, out-of-range detection and a completion flag.
module reg_sel_decoder
  import reg_sel_pkg::*;
#(
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned N_OUT     = 8,
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             REQ,
  input  logic [1:0]       MODE,
  input  logic [SEL_W-1:0] LINEIN,
  output logic             READY,
  output logic [N_OUT-1:0] LINEOUT,
  output logic             DONE,
  output logic             ERR
);

  localparam int unsigned      IDX_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [7:0]       PULSE_LAST = 8'(PULSE_LEN);
  localparam logic [IDX_W-1:0] SCAN_LAST  = IDX_W'(N_OUT - 1);

  state_e             state_q, state_d;
  logic [N_OUT-1:0]   lineout_q, lineout_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [7:0]         pulse_cnt_q, pulse_cnt_d;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;

  logic [N_OUT-1:0]   dec_onehot;
  logic               dec_in_range;
  logic               accept;
  logic               bad_req;

  onehot_dec #(
    .SEL_W (SEL_W),
    .N_OUT (N_OUT)
  ) u_dec (
    .sel      (LINEIN),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  assign accept  = REQ & ready_q & EN;
  // Scan ignores LINEIN, so only hold and pulse can be out of range.
  assign bad_req = (MODE == MODE_RSVD) || ((MODE != MODE_SCAN) && !dec_in_range);

  always_comb begin
    state_d     = state_q;
    lineout_d   = lineout_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    pulse_cnt_d = pulse_cnt_q;
    scan_idx_d  = scan_idx_q;

    if (!EN) begin
      state_d     = ST_IDLE;
      lineout_d   = '0;
      ready_d     = 1'b1;
      pulse_cnt_d = '0;
      scan_idx_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ready_d = 1'b1;
          if (accept) begin
            if (bad_req) begin
              err_d     = 1'b1;
              lineout_d = '0;
            end else begin
              case (MODE)
                MODE_HOLD: begin
                  lineout_d = dec_onehot;
                  done_d    = 1'b1;
                end
                MODE_PULSE: begin
                  lineout_d   = dec_onehot;
                  ready_d     = 1'b0;
                  pulse_cnt_d = 8'd1;
                  state_d     = ST_PULSE;
                end
                default: begin
                  lineout_d    = '0;
                  lineout_d[0] = 1'b1;
                  ready_d      = 1'b0;
                  scan_idx_d   = '0;
                  state_d      = ST_SCAN;
                end
              endcase
            end
          end
        end
        ST_PULSE: begin
          // Counter holds the number of cycles the strobe has already been high.
          if (pulse_cnt_q == PULSE_LAST) begin
            lineout_d   = '0;
            done_d      = 1'b1;
            ready_d     = 1'b1;
            pulse_cnt_d = '0;
            state_d     = ST_IDLE;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 8'd1;
          end
        end
        ST_SCAN: begin
          if (scan_idx_q == SCAN_LAST) begin
            lineout_d  = '0;
            done_d     = 1'b1;
            ready_d    = 1'b1;
            scan_idx_d = '0;
            state_d    = ST_IDLE;
          end else begin
            lineout_d  = lineout_q << 1;
            scan_idx_d = scan_idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          lineout_d = '0;
          ready_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      lineout_q   <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pulse_cnt_q <= '0;
      scan_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      lineout_q   <= lineout_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pulse_cnt_q <= pulse_cnt_d;
      scan_idx_q  <= scan_idx_d;
    end
  end

  assign READY   = ready_q;
  assign LINEOUT = lineout_q;
  assign DONE    = done_q;
  assign ERR     = err_q;

  a_lineout_onehot0: assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(LINEOUT));
  a_done_err_excl:   assert property (@(posedge CLK) disable iff (!RSTN) !(DONE && ERR));

endmodule

// File: tb/tb_reg_sel_decoder.sv
// Scoreboard bench for reg_sel_decoder: expected output events are queued with their due cycle
// and a negedge monitor pops them whenever the watched DUT changes LINEOUT/READY or flags DONE/ERR.
module tb_reg_sel_decoder;

  localparam int unsigned PLEN = 3;

  logic       clk = 1'b0;
  logic       rstn, en, req, sel6;
  logic [1:0] mode;
  logic [2:0] linein;

  logic       rdy8, dn8, er8;
  logic [7:0] lo8;
  logic       rdy6, dn6, er6;
  logic [5:0] lo6;

  logic [7:0] mon_lo, prev_lo;
  logic       mon_rdy, mon_dn, mon_er, prev_rdy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] lo;
    logic       rdy;
    logic       dn;
    logic       er;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state for the random phases.
  logic [7:0] m_lo;
  logic       m_rdy;
  int         m_busy;
  int         m_left;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_sel_decoder #(
    .SEL_W     (3),
    .N_OUT     (8),
    .PULSE_LEN (PLEN)
  ) dut8 (
    .CLK     (clk),
    .RSTN    (rstn),
    .EN      (en),
    .REQ     (req),
    .MODE    (mode),
    .LINEIN  (linein),
    .READY   (rdy8),
    .LINEOUT (lo8),
    .DONE    (dn8),
    .ERR     (er8)
  );

  reg_sel_decoder #(
    .SEL_W     (3),
    .N_OUT     (6),
    .PULSE_LEN (PLEN)
  ) dut6 (
    .CLK     (clk),
    .RSTN    (rstn),
    .EN      (en),
    .REQ     (req),
    .MODE    (mode),
    .LINEIN  (linein),
    .READY   (rdy6),
    .LINEOUT (lo6),
    .DONE    (dn6),
    .ERR     (er6)
  );

  assign mon_lo  = sel6 ? {2'b00, lo6} : lo8;
  assign mon_rdy = sel6 ? rdy6 : rdy8;
  assign mon_dn  = sel6 ? dn6 : dn8;
  assign mon_er  = sel6 ? er6 : er8;

  always @(negedge clk or negedge rstn) begin
    ev_t ev;
    if (!rstn) begin
      prev_lo  = '0;
      prev_rdy = 1'b1;
    end else begin
      checks++;
      if (!$onehot0(mon_lo) || (mon_dn && mon_er)) begin
        errors++;
        $display("FAIL invariant cyc=%0d lineout=%h done=%b err=%b", cyc, mon_lo, mon_dn, mon_er);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        ev = exp_q.pop_front();
        $display("FAIL missing_event due=%0d now=%0d want lineout=%h ready=%b done=%b err=%b",
                 ev.cyc, cyc, ev.lo, ev.rdy, ev.dn, ev.er);
      end
      if (mon_dn || mon_er || (mon_lo != prev_lo) || (mon_rdy != prev_rdy)) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got lineout=%h ready=%b done=%b err=%b",
                   cyc, mon_lo, mon_rdy, mon_dn, mon_er);
        end else begin
          ev = exp_q.pop_front();
          if (ev.lo !== mon_lo || ev.rdy !== mon_rdy || ev.dn !== mon_dn || ev.er !== mon_er) begin
            errors++;
            $display("FAIL event cyc=%0d got lineout=%h ready=%b done=%b err=%b want lineout=%h ready=%b done=%b err=%b",
                     cyc, mon_lo, mon_rdy, mon_dn, mon_er, ev.lo, ev.rdy, ev.dn, ev.er);
          end
        end
      end
      prev_lo  = mon_lo;
      prev_rdy = mon_rdy;
    end
  end

  task automatic step(input logic e, input logic r, input logic [1:0] m, input logic [2:0] l);
    en     = e;
    req    = r;
    mode   = m;
    linein = l;
    @(posedge clk);
    #1;
  endtask

  // Queue an event expected dc cycles after the current one.
  task automatic expect_ev(input int dc, input logic [7:0] lo, input logic rdy, input logic dn,
                           input logic er);
    ev_t e;
    e.cyc = cyc + dc;
    e.lo  = lo;
    e.rdy = rdy;
    e.dn  = dn;
    e.er  = er;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_lo   = '0;
    m_rdy  = 1'b1;
    m_busy = 0;
    m_left = 0;
  endtask

  task automatic rand_step(input int n, input bit force_off);
    logic       e, r, dn, er, prdy;
    logic [1:0] m;
    logic [2:0] l;
    logic [7:0] plo;
    e    = force_off ? 1'b0 : ($urandom_range(0, 9) != 0);
    r    = 1'($urandom_range(0, 1));
    m    = 2'($urandom_range(0, 3));
    l    = 3'($urandom_range(0, 7));
    plo  = m_lo;
    prdy = m_rdy;
    dn   = 1'b0;
    er   = 1'b0;
    if (!e) begin
      model_reset();
    end else if (m_busy == 1) begin
      if (m_left == 1) begin
        m_lo = '0; m_rdy = 1'b1; dn = 1'b1; m_busy = 0;
      end else begin
        m_left--;
      end
    end else if (m_busy == 2) begin
      if (m_lo[n-1]) begin
        m_lo = '0; m_rdy = 1'b1; dn = 1'b1; m_busy = 0;
      end else begin
        m_lo = m_lo << 1;
      end
    end else if (r) begin
      if (m == 2'b11 || (m != 2'b10 && int'(l) >= n)) begin
        er = 1'b1; m_lo = '0;
      end else if (m == 2'b00) begin
        m_lo = 8'h01 << l; dn = 1'b1;
      end else if (m == 2'b01) begin
        m_lo = 8'h01 << l; m_rdy = 1'b0; m_busy = 1; m_left = PLEN;
      end else begin
        m_lo = 8'h01; m_rdy = 1'b0; m_busy = 2;
      end
    end
    if (dn || er || (m_lo != plo) || (m_rdy != prdy)) expect_ev(1, m_lo, m_rdy, dn, er);
    step(e, r, m, l);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; req = 1'b0; mode = 2'b00; linein = '0; sel6 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_lineout", 32'(lo8), 32'h0);
    check("reset_ready", 32'(rdy8), 32'h1);
    check("reset_done", 32'(dn8), 32'h0);
    check("reset_err", 32'(er8), 32'h0);
    check("reset_lineout6", 32'(lo6), 32'h0);
    rstn = 1'b1;
    step(1, 0, 2'b00, 0);

    // HOLD, including hold-until-next-accept and back-to-back accepts
    expect_ev(1, 8'h20, 1, 1, 0); step(1, 1, 2'b00, 5);
    step(1, 0, 2'b00, 5); step(1, 0, 2'b00, 5);
    check("hold_keeps", 32'(lo8), 32'h20);
    expect_ev(1, 8'h01, 1, 1, 0); step(1, 1, 2'b00, 0);
    expect_ev(1, 8'h08, 1, 1, 0); step(1, 1, 2'b00, 3);
    expect_ev(1, 8'h08, 1, 1, 0); step(1, 1, 2'b00, 3);
    step(1, 0, 2'b00, 0);

    // PULSE: three cycles high, requests in the busy window ignored
    expect_ev(1, 8'h04, 0, 0, 0); expect_ev(4, 8'h00, 1, 1, 0);
    step(1, 1, 2'b01, 2); step(1, 1, 2'b00, 6); step(1, 0, 2'b00, 0);
    step(1, 1, 2'b10, 0); step(1, 0, 2'b00, 0);

    // SCAN over all eight lines
    for (int k = 1; k <= 8; k++) expect_ev(k, 8'(1 << (k - 1)), 0, 0, 0);
    expect_ev(9, 8'h00, 1, 1, 0);
    step(1, 1, 2'b10, 0);
    repeat (9) step(1, 0, 2'b00, 0);

    // Abort a scan with EN low at the third line; nothing accepted while EN is low
    expect_ev(1, 8'h01, 0, 0, 0); expect_ev(2, 8'h02, 0, 0, 0);
    expect_ev(3, 8'h04, 0, 0, 0); expect_ev(4, 8'h00, 1, 0, 0);
    step(1, 1, 2'b10, 0); step(1, 0, 2'b00, 0); step(1, 0, 2'b00, 0); step(0, 0, 2'b00, 0);
    step(0, 1, 2'b00, 1);
    check("en_low_no_accept", 32'(lo8), 32'h0);
    step(1, 0, 2'b00, 0);

    // Asynchronous reset mid-pulse
    expect_ev(1, 8'h04, 0, 0, 0); step(1, 1, 2'b01, 2); step(1, 0, 2'b00, 0);
    #1 rstn = 1'b0;
    #1;
    check("async_lineout", 32'(lo8), 32'h0);
    check("async_ready", 32'(rdy8), 32'h1);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 2'b00, 0);

    // Errors and boundaries on the six-output instance
    sel6 = 1'b1;
    expect_ev(1, 8'h20, 1, 1, 0); step(1, 1, 2'b00, 5);
    expect_ev(1, 8'h00, 1, 0, 1); step(1, 1, 2'b00, 7);
    step(1, 0, 2'b00, 0);
    expect_ev(1, 8'h00, 1, 0, 1); step(1, 1, 2'b11, 1);
    expect_ev(1, 8'h00, 1, 0, 1); step(1, 1, 2'b01, 6);
    for (int k = 1; k <= 6; k++) expect_ev(k, 8'(1 << (k - 1)), 0, 0, 0);
    expect_ev(7, 8'h00, 1, 1, 0);
    step(1, 1, 2'b10, 7);
    repeat (7) step(1, 0, 2'b00, 0);

    // Random traffic against the model, six-output then eight-output instance
    model_reset();
    for (int i = 0; i < 4000; i++) rand_step(6, i == 3999);
    sel6 = 1'b0;
    model_reset();
    for (int i = 0; i < 4000; i++) rand_step(8, i == 3999);
    step(1, 0, 2'b00, 0); step(1, 0, 2'b00, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
